// File: rtl/mem_fetch_ncl_bridge.sv
// ---------------------------------------------------------------------------
// mem_fetch_ncl_bridge
//
// Fetches bytes from a synchronous memory and presents them to an NCL
// (dual-rail, return-to-null) consumer. Each handshake delivers one byte
// together with a phase tag. The tag alternates instruction / constant, and
// a new fetch address forces it back to instruction.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : fetch enable; low parks the block in IDLE between handshakes
//   pc_load           : one-cycle request to redirect the fetch address
//   pc_load_val       : redirect address
//   mem_rd, mem_addr  : synchronous memory read strobe and address (addr = pc)
//   mem_rdata         : read data, valid the cycle after mem_rd
//   ki                : NCL completion from the consumer (1 = want data, 0 = want null),
//                       asynchronous to clk
//   PH0_t, PH0_f      : dual-rail phase (true = instruction byte)
//   D_t, D_f          : dual-rail data byte
//
// SYNC_STAGES must be 2 or 3.
// ---------------------------------------------------------------------------
module mem_fetch_ncl_bridge #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              ki,
    output logic              PH0_t,
    output logic              PH0_f,
    output logic [7:0]        D_t,
    output logic [7:0]        D_f
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_DATA,
        S_NULL
    } state_t;

    state_t              state, state_next;
    logic [SYNC_STAGES-1:0] ki_sync;
    logic                ki_s;
    logic [ADDR_W-1:0]   pc;
    logic                phase_instr;
    logic [7:0]          data_q;
    logic                load_pend;
    logic [ADDR_W-1:0]   load_val;
    logic                null_exit;
    logic                load_req;
    logic [ADDR_W-1:0]   load_addr;
    logic                apply_load;
    logic                ph0_t_q, ph0_f_q;
    logic [7:0]          d_t_q, d_f_q;

    // ki crosses in from the asynchronous NCL domain; only the last stage is used.
    // NOTE: every sequential block uses non-blocking assignments so all flops
    // sample the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ki_sync <= '0;
        end else begin
            ki_sync <= {ki_sync[SYNC_STAGES-2:0], ki};
        end
    end

    assign ki_s = ki_sync[SYNC_STAGES-1];

    // A load presented this cycle beats one latched earlier.
    assign null_exit  = (state == S_NULL) && ki_s;
    assign load_req   = pc_load || load_pend;
    assign load_addr  = pc_load ? pc_load_val : load_val;
    assign apply_load = load_req && ((state == S_IDLE) || null_exit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment at the top of this block keeps state_next
    // defined on every path, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (en && ki_s) state_next = S_READ;
            S_READ:    state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_DATA;
            S_DATA:    if (!ki_s) state_next = S_NULL;
            S_NULL:    if (ki_s) state_next = en ? S_READ : S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Fetch address, phase and the pending-load latch. The increment and the
    // phase toggle only happen when a handshake retires (NULL exit).
    // NOTE: all control and datapath flops are reset so the rails come up NULL;
    // there is no memory array in this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            phase_instr <= 1'b1;
            load_pend   <= 1'b0;
            load_val    <= '0;
        end else if (apply_load) begin
            pc          <= load_addr;
            phase_instr <= 1'b1;
            load_pend   <= 1'b0;
        end else begin
            if (null_exit) begin
                pc          <= pc + ADDR_W'(1);
                phase_instr <= ~phase_instr;
            end
            if (pc_load) begin
                load_pend <= 1'b1;
                load_val  <= pc_load_val;
            end
        end
    end

    // Rails are driven straight from flops that all load on the same edge, so
    // a wavefront appears and disappears in one step with no partial codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ph0_t_q <= 1'b0;
            ph0_f_q <= 1'b0;
            d_t_q   <= '0;
            d_f_q   <= '0;
        end else if (state == S_CAPTURE) begin
            data_q  <= mem_rdata;
            ph0_t_q <= phase_instr;
            ph0_f_q <= ~phase_instr;
            d_t_q   <= mem_rdata;
            d_f_q   <= ~mem_rdata;
        end else if (state_next == S_DATA) begin
            ph0_t_q <= phase_instr;
            ph0_f_q <= ~phase_instr;
            d_t_q   <= data_q;
            d_f_q   <= ~data_q;
        end else begin
            ph0_t_q <= 1'b0;
            ph0_f_q <= 1'b0;
            d_t_q   <= '0;
            d_f_q   <= '0;
        end
    end

    assign mem_rd   = (state == S_READ);
    assign mem_addr = pc;
    assign PH0_t    = ph0_t_q;
    assign PH0_f    = ph0_f_q;
    assign D_t      = d_t_q;
    assign D_f      = d_f_q;

endmodule

// File: tb/tb_mem_fetch_ncl_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_fetch_ncl_bridge
//
// Stimulus acts as the NCL consumer and the fetch controller. For each
// handshake it pushes the expected fetch address and wavefront into queues;
// an independent monitor pops them when the DUT strobes mem_rd or raises a
// wavefront. The reference model is just "next address, next phase".
// ---------------------------------------------------------------------------
module tb_mem_fetch_ncl_bridge;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;
    logic              ki;
    logic              PH0_t, PH0_f;
    logic [7:0]        D_t, D_f;

    always #5 clk = ~clk;

    mem_fetch_ncl_bridge #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .ki          (ki),
        .PH0_t       (PH0_t),
        .PH0_f       (PH0_f),
        .D_t         (D_t),
        .D_f         (D_f)
    );

    // Synchronous memory: data one cycle after the strobe.
    logic [7:0] mem [256];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       phase;
        logic [7:0] data;
    } wave_t;

    wave_t      wave_q[$];
    logic [7:0] addr_q[$];

    // Reference model: where the next fetch goes and which phase it carries.
    logic [7:0] m_pc;
    logic       m_instr;

    function automatic logic wave_full();
        return (PH0_t ^ PH0_f) && ((D_t ^ D_f) == 8'hFF);
    endfunction

    function automatic logic rails_zero();
        return {PH0_t, PH0_f, D_t, D_f} == 18'd0;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [17:0] prev_rails;
        logic [17:0] cur;
        wave_t       w;
        prev_rails = '0;
        forever begin
            @(negedge clk);
            cur = {PH0_t, PH0_f, D_t, D_f};
            if (rst_n === 1'b1) begin
                check("pair_exclusive", {31'd0, (PH0_t & PH0_f) | (|(D_t & D_f))}, 32'd0);
                if (mem_rd) begin
                    if (addr_q.size() == 0) check("spurious_mem_rd", {31'd0, mem_rd}, 32'd0);
                    else                    check("fetch_addr", {24'd0, mem_addr}, {24'd0, addr_q.pop_front()});
                end
                if (cur != 18'd0) begin
                    if (prev_rails == 18'd0) begin
                        check("complete_wavefront", {31'd0, wave_full()}, 32'd1);
                        if (wave_q.size() == 0) begin
                            check("spurious_wavefront", wave_q.size(), 32'd1);
                        end else begin
                            w = wave_q.pop_front();
                            check("phase", {31'd0, PH0_t}, {31'd0, w.phase});
                            check("data", {24'd0, D_t}, {24'd0, w.data});
                        end
                    end else begin
                        check("wave_stable", {14'd0, cur}, {14'd0, prev_rails});
                    end
                end
            end
            prev_rails = cur;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic model_reset();
        wave_q.delete();
        addr_q.delete();
        m_pc    = 8'h00;
        m_instr = 1'b1;
    endtask

    task automatic wait_wave();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = wave_full();
        end
        check("wave_arrives", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_null();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = rails_zero();
        end
        check("null_arrives", {31'd0, got}, 32'd1);
    endtask

    // One full four-phase handshake. Optionally pulses pc_load and/or drops en
    // while the wavefront is up. Leaves ki=0 (block parked in NULL) unless en
    // was dropped, in which case the block is walked back to IDLE.
    task automatic handshake(input int hold, input logic do_load, input logic [7:0] lval,
                             input logic drop_en);
        logic [7:0] exp_data;
        exp_data = mem[m_pc];
        addr_q.push_back(m_pc);
        wave_q.push_back('{phase: m_instr, data: exp_data});
        en = 1'b1;
        #1 ki = 1'b1;
        wait_wave();
        check("d_f_complement", {24'd0, D_f}, {24'd0, ~exp_data});
        if (do_load) begin
            pc_load     = 1'b1;
            pc_load_val = lval;
            @(negedge clk);
            pc_load     = 1'b0;
        end
        if (drop_en) en = 1'b0;
        repeat (hold) @(negedge clk);
        #1 ki = 1'b0;
        wait_null();
        if (do_load) begin
            m_pc    = lval;
            m_instr = 1'b1;
        end else begin
            m_pc    = m_pc + 8'd1;
            m_instr = ~m_instr;
        end
        if (drop_en) begin
            #1 ki = 1'b1;
            repeat (10) @(negedge clk);
            check("idle_pc", {24'd0, mem_addr}, {24'd0, m_pc});
            check("idle_no_rd", {31'd0, mem_rd}, 32'd0);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        ki = 1'b0;
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        ki          = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_rails", {14'd0, PH0_t, PH0_f, D_t, D_f}, 32'd0);
        #2 rst_n = 1'b1;

        // No fetch until ki is seen, even with en high
        en = 1'b1;
        repeat (10) @(negedge clk);
        check("no_read_before_ki", {31'd0, mem_rd}, 32'd0);

        // Single fetch of 0xA5 at address 0
        mem[0] = 8'hA5;
        handshake(2, 1'b0, 8'h00, 1'b0);

        // Three handshakes from reset; the last drops en so pc can be observed
        pulse_reset();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        handshake(1, 1'b0, 8'h00, 1'b0);
        handshake(3, 1'b0, 8'h00, 1'b0);
        handshake(0, 1'b0, 8'h00, 1'b1);
        check("pc_after_three", {24'd0, mem_addr}, 32'd3);

        // Load while idle takes effect at once and forces instruction phase
        pc_load     = 1'b1;
        pc_load_val = 8'h80;
        @(negedge clk);
        pc_load     = 1'b0;
        m_pc        = 8'h80;
        m_instr     = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_load_addr", {24'd0, mem_addr}, 32'h80);
        handshake(1, 1'b0, 8'h00, 1'b0);

        // Load 0xFF during DATA, then wrap to 0x00
        handshake(1, 1'b1, 8'hFF, 1'b0);
        handshake(2, 1'b0, 8'h00, 1'b0);
        handshake(2, 1'b0, 8'h00, 1'b0);

        // Long stall with ki held high in DATA
        handshake(50, 1'b0, 8'h00, 1'b0);

        // Randomized handshakes
        for (int n = 0; n < 30; n++) begin
            handshake($urandom_range(0, 6), ($urandom_range(0, 4) == 0),
                      8'($urandom), ($urandom_range(0, 5) == 0));
        end

        // Reset in the middle of DATA: rails drop without a clock edge
        addr_q.push_back(m_pc);
        wave_q.push_back('{phase: m_instr, data: mem[m_pc]});
        en = 1'b1;
        #1 ki = 1'b1;
        wait_wave();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rails", {14'd0, PH0_t, PH0_f, D_t, D_f}, 32'd0);
        check("async_rst_addr", {24'd0, mem_addr}, 32'd0);
        ki = 1'b0;
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        handshake(1, 1'b0, 8'h00, 1'b0);
        handshake(1, 1'b0, 8'h00, 1'b0);

        repeat (5) @(negedge clk);
        check("queues_drained", wave_q.size() + addr_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
